// File: rtl/tile_spawner.sv
// tile_spawner: after a settled 2048 move, drops one new tile into a
// pseudo-randomly chosen empty cell of the 4x4 board.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request pulse, sampled only while idle
//   moved           board changed by the move (sampled with start)
//   matrix          settled board, 16 x 12-bit cells, 0 = empty
//   out_matrix      board after the spawn, updated only in DONE
//   busy            high in every state except IDLE
//   done            one-cycle completion pulse
//   spawned         a tile was placed (held until next start)
//   full            out_matrix has no empty cell (held until next start)
//   spawn_row/col   coordinates of the placed tile (held until next start)
//
// Build option: define FOUR_TILE_EN to spawn a 4 instead of a 2 roughly
// one time in sixteen. Without it the new tile is always a 2.

module tile_spawner #(
    parameter logic [15:0] SEED = 16'hB5A3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  moved,
    input  logic [3:0][3:0][11:0] matrix,
    output logic [3:0][3:0][11:0] out_matrix,
    output logic                  busy,
    output logic                  done,
    output logic                  spawned,
    output logic                  full,
    output logic [1:0]            spawn_row,
    output logic [1:0]            spawn_col
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_PICK,
        S_PLACE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0]            lfsr;
    logic                   lfsr_fb;
    logic [3:0][3:0][11:0]  board;
    logic [3:0]             idx;
    logic [4:0]             zc;
    logic [4:0]             zc_inc;
    logic [3:0]             k;
    logic [4:0]             zs;
    logic [11:0]            cur_cell;
    logic                   cell_zero;
    logic                   pick_stay;
    logic                   hit;
    logic                   board_has_zero;
    logic [11:0]            tile_now;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign cur_cell  = board[idx[3:2]][idx[1:0]];
    assign cell_zero = (cur_cell == 12'd0);
    assign zc_inc    = zc + {4'd0, cell_zero};

    // Modulo by repeated subtraction: k ends below zc.
    assign pick_stay = ({1'b0, k} >= zc);

    // The k-th empty cell (zero-based) in scan order gets the tile.
    assign hit = (state == S_PLACE) && cell_zero && (zs == {1'b0, k});

    always_comb begin
        board_has_zero = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (board[r][c] == 12'd0) begin
                    board_has_zero = 1'b1;
                end
            end
        end
    end

`ifdef FOUR_TILE_EN
    // Value is decided from the LFSR in the first PLACE cycle and held
    // for the rest of the scan.
    logic [11:0] tile_first;
    logic [11:0] tile_q;

    assign tile_first = (lfsr[7:4] == 4'h0) ? 12'd4 : 12'd2;
    assign tile_now   = (idx == 4'd0) ? tile_first : tile_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_q <= 12'd2;
        end else if (state == S_PLACE && idx == 4'd0) begin
            tile_q <= tile_first;
        end
    end
`else
    assign tile_now = 12'd2;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = moved ? S_COUNT : S_DONE;
                end
            end
            S_COUNT: begin
                if (idx == 4'd15) begin
                    state_nx = (zc_inc == 5'd0) ? S_DONE : S_PICK;
                end
            end
            S_PICK: begin
                if (!pick_stay) begin
                    state_nx = S_PLACE;
                end
            end
            S_PLACE: begin
                if (idx == 4'd15) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // Datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= SEED_EFF;
            board      <= '0;
            idx        <= 4'd0;
            zc         <= 5'd0;
            zs         <= 5'd0;
            k          <= 4'd0;
            out_matrix <= '0;
            spawned    <= 1'b0;
            full       <= 1'b0;
            spawn_row  <= 2'd0;
            spawn_col  <= 2'd0;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        board     <= matrix;
                        spawned   <= 1'b0;
                        full      <= 1'b0;
                        spawn_row <= 2'd0;
                        spawn_col <= 2'd0;
                        idx       <= 4'd0;
                        zc        <= 5'd0;
                        zs        <= 5'd0;
                    end
                end
                S_COUNT: begin
                    idx <= idx + 4'd1;
                    zc  <= zc_inc;
                    if (idx == 4'd15) begin
                        if (zc_inc == 5'd0) begin
                            full <= 1'b1;
                        end else begin
                            k <= lfsr[3:0];
                        end
                    end
                end
                S_PICK: begin
                    // zc <= k <= 15 whenever we subtract, so zc[3:0] is exact.
                    if (pick_stay) begin
                        k <= k - zc[3:0];
                    end
                end
                S_PLACE: begin
                    idx <= idx + 4'd1;
                    if (cell_zero) begin
                        zs <= zs + 5'd1;
                    end
                    if (hit) begin
                        board[idx[3:2]][idx[1:0]] <= tile_now;
                        spawned   <= 1'b1;
                        spawn_row <= idx[3:2];
                        spawn_col <= idx[1:0];
                    end
                end
                S_DONE: begin
                    out_matrix <= board;
                    full       <= ~board_has_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_spawner.sv
// Testbench for tile_spawner: directed boards, a queue of expected
// results, and an independent monitor that checks each completion.

module tb_tile_spawner;

    typedef logic [3:0][3:0][11:0] board_t;

    typedef struct {
        board_t     mat;
        logic       sp;
        logic       fl;
        logic [1:0] row;
        logic [1:0] col;
        int         lat;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       moved;
    board_t     matrix;
    board_t     out_matrix;
    logic       busy;
    logic       done;
    logic       spawned;
    logic       full;
    logic [1:0] spawn_row;
    logic [1:0] spawn_col;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int cyc    = 0;
    int t0     = 0;

    exp_t q[$];
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    tile_spawner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .moved      (moved),
        .matrix     (matrix),
        .out_matrix (out_matrix),
        .busy       (busy),
        .done       (done),
        .spawned    (spawned),
        .full       (full),
        .spawn_row  (spawn_row),
        .spawn_col  (spawn_col)
    );

    function automatic logic [15:0] step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] x, input int n);
        logic [15:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = step(y);
        return y;
    endfunction

    // Software LFSR: free-running from the reset seed.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= 16'hB5A3;
        else     m_lfsr <= step(m_lfsr);
    end

    task automatic chk_v(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_b(input string nm, input board_t act, input board_t exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic int zeros(input board_t b);
        int n;
        n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == 12'd0) n++;
        return n;
    endfunction

    // Tile value for a run whose start edge saw l0 and whose PICK took p cycles.
    function automatic logic [11:0] tile_of(input logic [15:0] l0, input int p);
        logic [11:0] tv;
`ifdef FOUR_TILE_EN
        logic [15:0] x;
        x  = adv(l0, 17 + p);
        tv = (x[7:4] == 4'h0) ? 12'd4 : 12'd2;
`else
        tv = 12'd2;
        if (p < 0) tv = l0[11:0];
`endif
        return tv;
    endfunction

    // Behavioural result of one operation given the LFSR value in the
    // cycle whose closing edge samples start.
    function automatic exp_t predict(input board_t b, input logic mv,
                                     input logic [15:0] l0);
        exp_t e;
        int zc, k0, k, p, seen;
        logic [15:0] lk;
        e.mat = b; e.sp = 1'b0; e.fl = 1'b0;
        e.row = 2'd0; e.col = 2'd0; e.nm = "";
        zc = zeros(b);
        if (!mv) begin
            e.fl  = (zc == 0);
            e.lat = 1;
            return e;
        end
        if (zc == 0) begin
            e.fl  = 1'b1;
            e.lat = 17;
            return e;
        end
        lk   = adv(l0, 16);
        k0   = int'(lk[3:0]);
        p    = k0 / zc + 1;
        k    = k0 % zc;
        seen = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (b[r][c] == 12'd0) begin
                    if (seen == k) begin
                        e.mat[r][c] = tile_of(l0, p);
                        e.sp  = 1'b1;
                        e.row = 2'(r);
                        e.col = 2'(c);
                    end
                    seen++;
                end
            end
        end
        e.fl  = (zeros(e.mat) == 0);
        e.lat = 17 + p + 16;
        return e;
    endfunction

    // Monitor: outputs are compared in the idle cycle after done,
    // once out_matrix has taken the DONE-cycle update.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                int   lat;
                exp_t e;
                lat = cyc + 1 - t0;
                @(negedge clk);
                n_done++;
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done, want none");
                end else begin
                    e = q.pop_front();
                    chk_b({e.nm, ".matrix"},  out_matrix, e.mat);
                    chk_v({e.nm, ".spawned"}, spawned,    e.sp);
                    chk_v({e.nm, ".full"},    full,       e.fl);
                    chk_v({e.nm, ".row"},     spawn_row,  e.row);
                    chk_v({e.nm, ".col"},     spawn_col,  e.col);
                    chk_v({e.nm, ".latency"}, lat,        e.lat);
                end
            end
        end
    end

    // Issue one request and wait (bounded) for its completion.
    task automatic run(input board_t b, input logic mv, input exp_t e,
                       input string nm, input bit poke);
        int d0;
        board_t junk;
        junk = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                junk[r][c] = 12'd8;
        e.nm = nm;
        q.push_back(e);
        d0 = n_done;
        matrix = b;
        moved  = mv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (poke && i == 4) begin
                matrix = junk;
                moved  = 1'b1;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (n_done != d0) break;
        end
        start = 1'b0;
        if (n_done == d0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s.timeout: got no done in 200 cycles, want done", nm);
            q.delete();
        end
    endtask

    // Idle until the LFSR will hand k0 == target to an empty-board run.
    task automatic wait_k0(input int target);
        logic [15:0] lk;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            lk = adv(m_lfsr, 16);
            if (int'(lk[3:0]) == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_k0: got no k0=%0d in 400 cycles, want one", target);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        board_t a_brd, two_brd, empty_brd, one_brd, g_brd, want;
        exp_t   e;
        logic [15:0] lk;
        int     k0, d0;

        rst = 1'b1; start = 1'b0; moved = 1'b0; matrix = '0;

        a_brd = '0;
        a_brd[0][0] = 12'd2;
        a_brd[1][2] = 12'd4;
        a_brd[3][1] = 12'd8;
        a_brd[2][3] = 12'd2048;
        two_brd = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                two_brd[r][c] = 12'd2;
        empty_brd = '0;
        one_brd = two_brd;
        one_brd[3][3] = 12'd0;
        g_brd = two_brd;
        g_brd[0][2] = 12'd0;
        g_brd[1][3] = 12'd0;
        g_brd[2][1] = 12'd0;
        g_brd[3][0] = 12'd0;
        g_brd[3][2] = 12'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and free-running LFSR.
        @(negedge clk);
        chk_v("lfsr_first_step", dut.lfsr, 16'h6B46);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i % 3 == 0) chk_v("lfsr_vs_model", dut.lfsr, m_lfsr);
        end
        chk_b("rst.matrix",  out_matrix, '0);
        chk_v("rst.busy",    busy,       0);
        chk_v("rst.done",    done,       0);
        chk_v("rst.spawned", spawned,    0);
        chk_v("rst.full",    full,       0);
        chk_v("rst.row",     spawn_row,  0);
        chk_v("rst.col",     spawn_col,  0);

        // Unmoved board passes straight through.
        e = '{mat: a_brd, sp: 1'b0, fl: 1'b0, row: 2'd0, col: 2'd0, lat: 1, nm: ""};
        run(a_brd, 1'b0, e, "nomove", 1'b0);
        e = '{mat: two_brd, sp: 1'b0, fl: 1'b1, row: 2'd0, col: 2'd0, lat: 1, nm: ""};
        run(two_brd, 1'b0, e, "nomove_full", 1'b0);

        // Full board after a move: no spawn, full flagged.
        e = '{mat: two_brd, sp: 1'b0, fl: 1'b1, row: 2'd0, col: 2'd0, lat: 17, nm: ""};
        run(two_brd, 1'b1, e, "full_board", 1'b0);

        // Empty board with k0 = 5: cell 5 is row 1, col 1.
        wait_k0(5);
        want = '0;
        want[1][1] = tile_of(m_lfsr, 1);
        e = '{mat: want, sp: 1'b1, fl: 1'b0, row: 2'd1, col: 2'd1, lat: 34, nm: ""};
        run(empty_brd, 1'b1, e, "empty_k5", 1'b0);

        // Only cell 15 empty: PICK runs k0+1 cycles.
        lk = adv(m_lfsr, 16);
        k0 = int'(lk[3:0]);
        want = two_brd;
        want[3][3] = tile_of(m_lfsr, k0 + 1);
        e = '{mat: want, sp: 1'b1, fl: 1'b1, row: 2'd3, col: 2'd3,
              lat: 17 + k0 + 1 + 16, nm: ""};
        run(one_brd, 1'b1, e, "last_cell", 1'b0);

        // Five empty cells at varied LFSR phases; a start pulse while
        // busy must not disturb the run in progress.
        for (int j = 0; j < 3; j++) begin
            repeat (2 * j + 1) @(negedge clk);
            e = predict(g_brd, 1'b1, m_lfsr);
            run(g_brd, 1'b1, e, $sformatf("five_empty%0d", j), j == 1);
        end

        // Start held during the DONE cycle only: ignored.
        e = '{mat: a_brd, sp: 1'b0, fl: 1'b0, row: 2'd0, col: 2'd0, lat: 1, nm: "done_start"};
        q.push_back(e);
        d0 = n_done;
        matrix = a_brd; moved = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        @(negedge clk);
        chk_v("done_start.done", done, 1);
        matrix = two_brd; moved = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_v("done_start.busy1", busy, 0);
        @(negedge clk);
        chk_v("done_start.busy2", busy, 0);
        chk_v("done_start.count", n_done - d0, 1);

        // Reset in the middle of PLACE aborts cleanly.
        matrix = empty_brd; moved = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (24) @(negedge clk);
        chk_v("abort.busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_v("abort.reseed", dut.lfsr, 16'hB5A3);
        @(negedge clk);
        rst = 1'b0;
        chk_b("abort.matrix",  out_matrix, '0);
        chk_v("abort.busy",    busy,       0);
        chk_v("abort.spawned", spawned,    0);
        chk_v("abort.full",    full,       0);
        chk_v("abort.row",     spawn_row,  0);
        chk_v("abort.col",     spawn_col,  0);

        wait_k0(5);
        want = '0;
        want[1][1] = tile_of(m_lfsr, 1);
        e = '{mat: want, sp: 1'b1, fl: 1'b0, row: 2'd1, col: 2'd1, lat: 34, nm: ""};
        run(empty_brd, 1'b1, e, "empty_k5_again", 1'b0);

`ifdef FOUR_TILE_EN
        // Wait for a phase where the empty-board spawn is a 4.
        begin
            bit got4;
            got4 = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                e = predict(empty_brd, 1'b1, m_lfsr);
                if (e.mat[e.row][e.col] == 12'd4) begin
                    got4 = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk_v("four.found", got4, 1);
            if (got4) run(empty_brd, 1'b1, e, "four_tile", 1'b0);
        end
`endif

        repeat (2) @(negedge clk);
        chk_v("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
